// File: rtl/disp_mux_n.sv
`default_nettype none
// ============================================================================
//  disp_mux_n : time-multiplexed common-anode 7-segment scanner, with a
//  per-frame shadow buffer, blank/blink, leading-zero suppression and PWM.
//  Revision 1.0
// ============================================================================
module disp_mux_n #(
  parameter int DIGITS  = 4,
  parameter int DIV_W   = 16,
  parameter int BLINK_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sseg,
  output logic                  frame
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    p;
  logic [IDX_W-1:0]    idx;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [4*DIGITS-1:0] sh_hex;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [DIGITS-1:0]   sh_blink;

  logic                wrap;
  logic                frame_end;
  logic [DIGITS-1:0]   zero;
  logic [DIGITS-1:0]   sup;
  logic                tail;
  logic [3:0]          cur_hex;
  logic                cur_dp;
  logic                cur_dark;
  logic                gate;
  logic                dark;
  logic [DIGITS-1:0]   an_nxt;
  logic [7:0]          sseg_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign wrap      = &p;
  assign frame_end = wrap && (idx == LAST_IDX);

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_zero
      assign zero[i] = (sh_hex[4*i +: 4] == 4'h0) && !sh_dp[i];
    end
  endgenerate

  // A digit is a leading zero when it and every more-significant digit are blank-valued.
  always_comb begin
    tail = 1'b1;
    sup  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail   = tail & zero[i];
      sup[i] = lz_en && tail && (i != 0);
    end
  end

  always_comb begin
    cur_hex  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_hex  = sh_hex[4*i +: 4];
        cur_dp   = sh_dp[i];
        cur_dark = sh_blank[i] | (sh_blink[i] & blink_cnt[BLINK_W-1]) | sup[i];
      end
    end
  end

  assign gate     = (p[DIV_W-1 -: 4] <= bright);
  assign dark     = cur_dark | ~gate;
  assign an_nxt   = dark ? {DIGITS{1'b1}} : ~(DIGITS'(1) << idx);
  assign sseg_nxt = dark ? 8'hFF : {~cur_dp, seg7(cur_hex)};

  always_ff @(posedge clk) begin
    if (reset) begin
      p         <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      sh_hex    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      sh_blink  <= '0;
      frame     <= 1'b0;
      an        <= '1;
      sseg      <= 8'hFF;
    end else begin
      p         <= p + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (wrap) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        sh_hex   <= hex;
        sh_dp    <= dp_in;
        sh_blank <= blank;
        sh_blink <= blink;
      end
      frame <= frame_end;
      an    <= an_nxt;
      sseg  <= sseg_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_mux_n.sv
`default_nettype none
// Randomised scoreboard bench for disp_mux_n: a cycle-count reference model
// predicts every output word, a separate monitor pops and compares.
module tb_disp_mux_n;

  localparam int DIGITS  = 4;
  localparam int DIV_W   = 4;
  localparam int BLINK_W = 8;
  localparam int DWELL   = 1 << DIV_W;
  localparam int FRAME   = DIGITS * DWELL;
  localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
    logic              fr;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [4*DIGITS-1:0] hex;
  logic [DIGITS-1:0]   dp_in, blank, blink;
  logic                lz_en;
  logic [3:0]          bright;
  logic [DIGITS-1:0]   an;
  logic [7:0]          sseg;
  logic                frame;

  disp_mux_n #(.DIGITS(DIGITS), .DIV_W(DIV_W), .BLINK_W(BLINK_W)) dut (
    .clk(clk), .reset(reset), .hex(hex), .dp_in(dp_in), .blank(blank), .blink(blink),
    .lz_en(lz_en), .bright(bright), .an(an), .sseg(sseg), .frame(frame)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycles since reset release plus the latched frame data.
  bit                  mdl_on = 0;
  int                  cnt = 0;
  logic [4*DIGITS-1:0] m_hex;
  logic [DIGITS-1:0]   m_dp, m_blank, m_blink;

  task automatic model_step();
    int   d, pv, slot, hv;
    bit   ph, sup, dark;
    exp_t e;
    if (reset) begin
      mdl_on  = 1;
      cnt     = 0;
      m_hex   = '0;
      m_dp    = '0;
      m_blank = '1;
      m_blink = '0;
      e.an = '1; e.seg = 8'hFF; e.fr = 1'b0;
      exp_q.push_back(e);
    end else if (mdl_on) begin
      pv   = cnt % DWELL;
      d    = (cnt / DWELL) % DIGITS;
      ph   = ((cnt >> (BLINK_W - 1)) & 1) != 0;
      slot = pv >> (DIV_W - 4);
      hv   = int'((m_hex >> (4 * d)) & 16'hF);
      sup  = lz_en && d >= 1 && ((m_hex >> (4 * d)) == 0) && ((m_dp >> d) == 0);
      dark = m_blank[d] || (m_blink[d] && ph) || sup || (slot > int'(bright));
      e.an  = dark ? '1 : ~(DIGITS'(1) << d);
      e.seg = dark ? 8'hFF : (m_dp[d] ? (SEG_TAB[hv] & 8'h7F) : SEG_TAB[hv]);
      e.fr  = (cnt % FRAME) == FRAME - 1;
      exp_q.push_back(e);
      if (e.fr) begin
        m_hex = hex; m_dp = dp_in; m_blank = blank; m_blink = blink;
      end
      cnt++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare every registered output word, and frame spacing independently.
  initial begin
    exp_t e;
    int   gcyc = 0;
    int   last_fr = -1;
    forever begin
      @(posedge clk);
      #1;
      gcyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (an !== e.an || sseg !== e.seg || frame !== e.fr) begin
          errors++;
          $display("FAIL outputs cyc=%0d: got an=%b sseg=%h frame=%b, want an=%b sseg=%h frame=%b",
                   gcyc, an, sseg, frame, e.an, e.seg, e.fr);
        end
      end
      if (reset) last_fr = -1;
      else if (frame === 1'b1) begin
        if (last_fr >= 0) begin
          checks++;
          if (gcyc - last_fr != FRAME) begin
            errors++;
            $display("FAIL frame_gap: got %0d cycles, want %0d", gcyc - last_fr, FRAME);
          end
        end
        last_fr = gcyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    reset = 1'b1; hex = 16'h1234; dp_in = '0; blank = '0; blink = '0; lz_en = 1'b0; bright = 4'd15;
    tick(3);
    reset = 1'b0;
    tick(100);
    hex = 16'hABCD;
    tick(150);
    lz_en = 1'b1; hex = 16'h0050; tick(140);
    hex = 16'h0000; tick(130);
    dp_in = 4'b1000; tick(130);
    dp_in = '0; lz_en = 1'b0; hex = 16'h1234;
    bright = 4'd3;  tick(130);
    bright = 4'd0;  tick(130);
    bright = 4'd15;
    blink = 4'b0001; tick(600);
    blink = '0; blank = 4'b0100; tick(140);
    blank = '0;
    found = 0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if ((cnt / DWELL) % DIGITS == 2) found = 1;
      else tick(1);
    end
    if (!found) begin
      errors++;
      $display("FAIL midframe_wait: got no idx=2 window, want one within %0d cycles", FRAME);
    end
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(140);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(5))
          0: hex    = 16'($urandom);
          1: dp_in  = 4'($urandom);
          2: blank  = 4'($urandom);
          3: blink  = 4'($urandom);
          4: lz_en  = 1'($urandom);
          default: bright = 4'($urandom);
        endcase
      end
      if ($urandom_range(20) == 0) hex = hex & 16'h00FF;
      reset = ($urandom_range(599) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
